// File: rtl/iris_axi_pkg.sv
// Shared types and constants for the iris AXI burst RAM slave.
package iris_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WRESP = 2'd2,
    ST_READ  = 2'd3
  } axi_state_e;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/iris_ram_array.sv
// Single-port synchronous RAM, per-byte write enables, 1-cycle registered read.
// Kept in its own module so the BSRAM inference pattern stays untouched.
module iris_ram_array #(
  parameter int DATA_WIDTH = 24,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Read output only updates on a read access, so it holds while the port idles.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/iris_axi_burst_ram.sv
// AXI4-style INCR-burst RAM slave: one transaction in flight, round-robin
// read/write arbitration onto a single RAM port, SLVERR on range/wlast faults.
module iris_axi_burst_ram
  import iris_axi_pkg::*;
#(
  parameter int  DATA_WIDTH = 24,
  parameter int  ADDR_WIDTH = 16,
  parameter int  MEM_DEPTH  = 65536,
  parameter int  LEN_WIDTH  = 8,
  parameter int  ID_WIDTH   = 4,
  localparam int STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [LEN_WIDTH-1:0]  axi_awlen,
  input  logic [ID_WIDTH-1:0]   axi_awid,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  input  logic [DATA_WIDTH-1:0] axi_wdata,
  input  logic [STRB_WIDTH-1:0] axi_wstrb,
  input  logic                  axi_wlast,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  output logic [1:0]            axi_bresp,
  output logic [ID_WIDTH-1:0]   axi_bid,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [LEN_WIDTH-1:0]  axi_arlen,
  input  logic [ID_WIDTH-1:0]   axi_arid,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic [DATA_WIDTH-1:0] axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rlast,
  output logic [ID_WIDTH-1:0]   axi_rid,
  output axi_state_e            dbg_state
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(MEM_DEPTH);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_L;
  endfunction

  axi_state_e            state_q, state_d;
  logic                  prio_w_q, prio_w_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, cnt_q, cnt_d;
  logic [ID_WIDTH-1:0]   id_q, id_d, rid_q, rid_d;
  logic                  err_q, err_d;
  logic                  iss_left_q, iss_left_d;
  logic                  pend_q, pend_d, pend_oor_q, pend_oor_d, pend_last_q, pend_last_d;
  logic                  rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  sel_w, rd_load, awready_c, arready_c;
  logic                  ram_en, ram_we;
  logic [RAM_AW-1:0]     ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // Handshakes: a beat transfers on the rising edge where valid && ready are both
  // high; ready may depend on valid, and a source holds its payload until accepted.
  always_comb begin
    state_d     = state_q;
    prio_w_d    = prio_w_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    id_d        = id_q;
    err_d       = err_q;
    iss_left_d  = iss_left_q;
    pend_d      = pend_q;
    pend_oor_d  = pend_oor_q;
    pend_last_d = pend_last_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    rid_d       = rid_q;
    awready_c   = 1'b0;
    arready_c   = 1'b0;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = addr_q[RAM_AW-1:0];
    sel_w       = axi_awvalid && (!axi_arvalid || prio_w_q);
    rd_load     = pend_q && (!rvalid_q || axi_rready);

    case (state_q)
      ST_IDLE: begin
        awready_c = sel_w;
        arready_c = axi_arvalid && !sel_w;
        if (sel_w) begin
          addr_d  = axi_awaddr;
          len_d   = axi_awlen;
          id_d    = axi_awid;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = ST_WRITE;
        end else if (axi_arvalid) begin
          // First beat is fetched during the grant cycle to hide RAM latency.
          ram_en      = in_range(axi_araddr);
          ram_addr    = axi_araddr[RAM_AW-1:0];
          addr_d      = axi_araddr + 1'b1;
          len_d       = axi_arlen;
          id_d        = axi_arid;
          cnt_d       = LEN_WIDTH'(1);
          iss_left_d  = (axi_arlen != '0);
          pend_d      = 1'b1;
          pend_last_d = (axi_arlen == '0);
          pend_oor_d  = !in_range(axi_araddr);
          state_d     = ST_READ;
        end
      end
      ST_WRITE: begin
        if (axi_wvalid) begin
          if (in_range(addr_q)) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          addr_d = addr_q + 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if ((cnt_q == len_q) || axi_wlast) begin
            if ((cnt_q == len_q) != axi_wlast) err_d = 1'b1;
            state_d = ST_WRESP;
          end
        end
      end
      ST_WRESP: begin
        if (axi_bready) begin
          err_d    = 1'b0;
          prio_w_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      ST_READ: begin
        if (rd_load) begin
          rvalid_d = 1'b1;
          rdata_d  = pend_oor_q ? '0 : ram_rdata;
          rresp_d  = pend_oor_q ? RESP_SLVERR : RESP_OKAY;
          rlast_d  = pend_last_q;
          rid_d    = id_q;
        end else if (rvalid_q && axi_rready) begin
          rvalid_d = 1'b0;
        end
        // Fetch the next beat only when the pending slot is free or draining now.
        if (iss_left_q && (!pend_q || rd_load)) begin
          ram_en      = in_range(addr_q);
          pend_d      = 1'b1;
          pend_last_d = (cnt_q == len_q);
          pend_oor_d  = !in_range(addr_q);
          addr_d      = addr_q + 1'b1;
          cnt_d       = cnt_q + 1'b1;
          iss_left_d  = (cnt_q != len_q);
        end else if (rd_load) begin
          pend_d = 1'b0;
        end
        if (rvalid_q && axi_rready && rlast_q) begin
          prio_w_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      prio_w_q    <= 1'b1;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      id_q        <= '0;
      err_q       <= 1'b0;
      iss_left_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_oor_q  <= 1'b0;
      pend_last_q <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      rresp_q     <= '0;
      rlast_q     <= 1'b0;
      rid_q       <= '0;
    end else begin
      state_q     <= state_d;
      prio_w_q    <= prio_w_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      id_q        <= id_d;
      err_q       <= err_d;
      iss_left_q  <= iss_left_d;
      pend_q      <= pend_d;
      pend_oor_q  <= pend_oor_d;
      pend_last_q <= pend_last_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rresp_q     <= rresp_d;
      rlast_q     <= rlast_d;
      rid_q       <= rid_d;
    end
  end

  iris_ram_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .STRB_WIDTH (STRB_WIDTH),
    .DEPTH      (MEM_DEPTH),
    .AW         (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (axi_wstrb),
    .addr  (ram_addr),
    .wdata (axi_wdata),
    .rdata (ram_rdata)
  );

  assign axi_awready = awready_c;
  assign axi_arready = arready_c;
  assign axi_wready  = (state_q == ST_WRITE);
  assign axi_bvalid  = (state_q == ST_WRESP);
  assign axi_bresp   = err_q ? RESP_SLVERR : RESP_OKAY;
  assign axi_bid     = id_q;
  assign axi_rvalid  = rvalid_q;
  assign axi_rdata   = rdata_q;
  assign axi_rresp   = rresp_q;
  assign axi_rlast   = rlast_q;
  assign axi_rid     = rid_q;
  assign dbg_state   = state_q;

endmodule
